// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the NCO clock generator: controller states,
// hold length and the increment saturation rule.
package clkgen_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } ctrl_state_e;

  localparam int HOLD_CYCLES = 4;
  localparam int MAX_ACC_W   = 48;

  // Clamp an increment to half the accumulator range (refclk/2 is the fastest output).
  function automatic logic [MAX_ACC_W-1:0] sat_inc(input logic [MAX_ACC_W-1:0] value,
                                                   input int acc_w);
    logic [MAX_ACC_W-1:0] half;
    half = {{(MAX_ACC_W-1){1'b0}}, 1'b1} << (acc_w - 1);
    return (value > half) ? half : value;
  endfunction

endpackage

// File: rtl/clkgen_nco_chan.sv
// One NCO channel: phase accumulator, increment register, registered MSB
// clock output and registered wrap strobe.
module clkgen_nco_chan
  import clkgen_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h51EB851F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             outclk,
  output logic             outclk_en
);

  localparam logic [ACC_W-1:0] RESET_INC = ACC_W'(sat_inc(MAX_ACC_W'(DEFAULT_INC), ACC_W));

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] inc_sat;
  logic [ACC_W:0]   sum;

  assign inc_sat = ACC_W'(sat_inc(MAX_ACC_W'(load_inc), ACC_W));
  assign sum     = {1'b0, acc} + {1'b0, inc};

  // A zero increment parks the output low regardless of the held phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      inc       <= RESET_INC;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else if (load) begin
      inc       <= inc_sat;
      acc       <= load_phase;
      outclk    <= (inc_sat != '0) && load_phase[ACC_W-1];
      outclk_en <= 1'b0;
    end else if (run) begin
      acc       <= sum[ACC_W-1:0];
      outclk    <= (inc != '0) && sum[ACC_W-1];
      outclk_en <= sum[ACC_W];
    end else begin
      acc       <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/clkgen_nco.sv
// Multi-channel NCO clock generator: hold/settle/lock controller, config
// handshake (transfer = cfg_valid & cfg_ready) and NUM_CLOCKS channels.
module clkgen_nco
  import clkgen_pkg::*;
#(
  parameter int               NUM_CLOCKS  = 2,
  parameter int               ACC_W       = 32,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h51EB851F),
  localparam int              CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
  input  logic [ACC_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  ctrl_state_e           state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_CLOCKS-1:0] chan_hit;
  logic                  chan_ok;
  logic                  xfer;
  logic                  xfer_ok;
  logic                  run;

  always_comb begin
    chan_hit = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) chan_hit[i] = (cfg_chan == CHAN_W'(i));
  end

  assign chan_ok   = |chan_hit;
  assign cfg_ready = (state != ST_HOLD);
  assign xfer      = cfg_valid & cfg_ready;
  assign xfer_ok   = xfer & chan_ok;
  assign run       = (state != ST_HOLD);
  assign dbg_state = state;

  // One counter serves both the hold length and the settle time.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = ST_SETTLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (xfer_ok) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_n = ST_LOCKED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (xfer_ok) begin
          state_n = ST_SETTLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state   <= ST_HOLD;
      cnt     <= '0;
      locked  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      locked  <= (state_n == ST_LOCKED);
      cfg_err <= xfer & ~chan_ok;
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clkgen_nco_chan #(
      .ACC_W      (ACC_W),
      .DEFAULT_INC(DEFAULT_INC)
    ) u_chan (
      .clk       (refclk),
      .rst       (rst),
      .run       (run),
      .load      (xfer & chan_hit[g]),
      .load_inc  (cfg_inc),
      .load_phase(cfg_phase),
      .outclk    (outclk[g]),
      .outclk_en (outclk_en[g])
    );
  end

endmodule

// File: tb/tb_clkgen_nco.sv
// Bench for clkgen_nco: cycle-level arithmetic model of the NCO channels and
// lock timing, checked every cycle, plus directed hand-computed checks.
module tb_clkgen_nco;

  localparam int NUM_CLOCKS  = 3;
  localparam int ACC_W       = 32;
  localparam int LOCK_CYCLES = 1024;
  localparam int CHAN_W      = 2;
  localparam int HOLD_LEN    = 4;
  localparam longint unsigned DEF_INC = 64'h51EB851F;
  localparam longint unsigned MODV    = 64'd1 << ACC_W;
  localparam longint unsigned HALF    = 64'd1 << (ACC_W - 1);

  logic                  refclk;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CHAN_W-1:0]     cfg_chan;
  logic [ACC_W-1:0]      cfg_inc;
  logic [ACC_W-1:0]      cfg_phase;
  logic [NUM_CLOCKS-1:0] outclk;
  logic [NUM_CLOCKS-1:0] outclk_en;
  logic                  locked;
  logic                  cfg_err;
  logic [1:0]            dbg_state;

  clkgen_nco #(
    .NUM_CLOCKS (NUM_CLOCKS),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .DEFAULT_INC(32'h51EB851F)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked),
    .cfg_err  (cfg_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  longint unsigned       m_acc[NUM_CLOCKS];
  longint unsigned       m_inc[NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] m_out;
  logic [NUM_CLOCKS-1:0] m_en;
  logic                  m_err;
  logic                  m_ready;
  logic                  m_locked;
  int                    age;
  int                    settle_age;

  function automatic longint unsigned clamp_inc(input longint unsigned v);
    return (v > HALF) ? HALF : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      m_acc[i] = 0;
      m_inc[i] = clamp_inc(DEF_INC);
    end
    m_out = '0; m_en = '0; m_err = 1'b0; m_ready = 1'b0; m_locked = 1'b0;
    age = 0; settle_age = 0;
  endtask

  task automatic model_step();
    bit ready, xfer;
    int tgt;
    longint unsigned s;
    ready = (age >= HOLD_LEN);
    xfer  = cfg_valid && ready;
    tgt   = int'(cfg_chan);
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (xfer && tgt == i) begin
        m_inc[i] = clamp_inc(longint'(cfg_inc));
        m_acc[i] = longint'(cfg_phase);
        m_en[i]  = 1'b0;
        m_out[i] = (m_inc[i] != 0) && cfg_phase[ACC_W-1];
      end else if (ready) begin
        s        = m_acc[i] + m_inc[i];
        m_en[i]  = (s >= MODV);
        m_acc[i] = s % MODV;
        m_out[i] = (m_inc[i] != 0) && (m_acc[i] >= HALF);
      end
    end
    m_err = xfer && (tgt >= NUM_CLOCKS);
    if (xfer && tgt < NUM_CLOCKS) settle_age = 0;
    else if (ready && settle_age < LOCK_CYCLES) settle_age++;
    if (age < HOLD_LEN) age++;
    m_ready  = (age >= HOLD_LEN);
    m_locked = m_ready && (settle_age >= LOCK_CYCLES);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // scoreboard compare, every cycle on the falling edge
  initial begin
    forever begin
      @(negedge refclk);
      check("outclk", longint'(outclk), longint'(m_out));
      check("outclk_en", longint'(outclk_en), longint'(m_en));
      check("locked", longint'(locked), longint'(m_locked));
      check("cfg_ready", longint'(cfg_ready), longint'(m_ready));
      check("cfg_err", longint'(cfg_err), longint'(m_err));
    end
  end

  // driver tasks
  task automatic send(input int chan, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] phase);
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_chan  = CHAN_W'(chan);
    cfg_inc   = inc;
    cfg_phase = phase;
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic release_and_time(output int r_edge, output int l_edge);
    r_edge = -1;
    l_edge = -1;
    @(negedge refclk);
    rst = 1'b0;
    for (int e = 1; e <= 2000; e++) begin
      @(posedge refclk);
      #1;
      if (cfg_ready && r_edge < 0) r_edge = e;
      if (locked) begin
        l_edge = e;
        break;
      end
    end
  endtask

  task automatic wait_locked(input int budget, output int edges);
    edges = 0;
    while (!locked && edges < budget) begin
      @(posedge refclk);
      #1;
      edges++;
    end
    if (!locked) edges = -1;
  endtask

  int pulses[NUM_CLOCKS];

  task automatic count_pulses(input int n);
    for (int i = 0; i < NUM_CLOCKS; i++) pulses[i] = 0;
    repeat (n) begin
      @(posedge refclk);
      #1;
      for (int i = 0; i < NUM_CLOCKS; i++) pulses[i] += int'(outclk_en[i]);
    end
  endtask

  // directed sequence
  initial begin
    int r_edge, l_edge, edges, highs, ens;
    logic [7:0] pat;

    rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; cfg_phase = '0;
    repeat (3) @(posedge refclk);
    #1;
    check("rst_ready", longint'(cfg_ready), 0);
    check("rst_locked", longint'(locked), 0);
    check("rst_outclk", longint'(outclk), 0);
    check("rst_outclk_en", longint'(outclk_en), 0);
    check("rst_cfg_err", longint'(cfg_err), 0);

    release_and_time(r_edge, l_edge);
    check("ready_edge", r_edge, 4);
    check("lock_edge", l_edge, 1028);

    count_pulses(3125);
    for (int i = 0; i < NUM_CLOCKS; i++) check("pulses_default", pulses[i], 1000);

    // quarter-rate clock on channel 1
    send(1, 32'h40000000, 32'h0);
    check("unlock_after_xfer", longint'(locked), 0);
    check("ch1_load_low", longint'(outclk[1]), 0);
    pat = '0; ens = 0;
    repeat (8) begin
      @(posedge refclk);
      #1;
      pat = {pat[6:0], outclk[1]};
      ens += int'(outclk_en[1]);
    end
    check("ch1_pattern", longint'(pat), 64'h66);
    check("ch1_en_count", ens, 2);
    wait_locked(2000, edges);
    check("relock_edges", edges, 1016);

    // over-range increment saturates to half rate
    send(0, 32'hFFFFFFFF, 32'h0);
    pat = '0; ens = 0;
    repeat (6) begin
      @(posedge refclk);
      #1;
      pat = {pat[6:0], outclk[0]};
      ens += int'(outclk_en[0]);
    end
    check("ch0_sat_pattern", longint'(pat[5:0]), 64'h2A);
    check("ch0_sat_en_count", ens, 3);

    // zero increment parks the channel
    send(2, 32'h0, 32'h80000000);
    highs = 0; ens = 0;
    repeat (10) begin
      @(posedge refclk);
      #1;
      highs += int'(outclk[2]);
      ens   += int'(outclk_en[2]);
    end
    check("ch2_zero_highs", highs, 0);
    check("ch2_zero_ens", ens, 0);

    // back-to-back transfers
    send(0, 32'h10000000, 32'h0);
    send(1, 32'h20000000, 32'h12345678);
    wait_locked(2000, edges);
    check("relock_after_b2b", edges, 1024);

    // invalid channel index
    send(3, 32'h00001234, 32'h00005678);
    check("err_pulse", longint'(cfg_err), 1);
    check("err_keeps_lock", longint'(locked), 1);
    @(posedge refclk);
    #1;
    check("err_single", longint'(cfg_err), 0);
    check("err_lock_after", longint'(locked), 1);

    // settle restarted by transfer, then by reset
    send(0, 32'h08000000, 32'h0);
    repeat (500) @(posedge refclk);
    send(1, 32'h0C000000, 32'h0);
    repeat (300) @(posedge refclk);
    #1;
    check("still_settling", longint'(locked), 0);
    @(negedge refclk);
    rst = 1'b1;
    #1;
    check("async_rst_ready", longint'(cfg_ready), 0);
    check("async_rst_outclk", longint'(outclk), 0);
    repeat (2) @(posedge refclk);
    release_and_time(r_edge, l_edge);
    check("ready_edge_2", r_edge, 4);
    check("lock_edge_2", l_edge, 1028);
    count_pulses(3125);
    for (int i = 0; i < NUM_CLOCKS; i++) check("pulses_after_rst", pulses[i], 1000);

    @(negedge refclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clkgen_nco.md
CLKGEN_NCO -- requirements
Module: clkgen_nco

Interface
REQ-001 Parameter NUM_CLOCKS, default 2, number of output clock channels (1..8).
REQ-002 Parameter ACC_W, default 32, phase-accumulator width in bits (16..48).
REQ-003 Parameter LOCK_CYCLES, default 1024, settle cycles before locked asserts (>=2).
REQ-004 Parameter DEFAULT_INC, default 32'h51EB851F, reset increment for every channel (16 MHz from 50 MHz).
REQ-005 refclk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  configuration accept.
REQ-009 cfg_chan  input  max(1,clog2(NUM_CLOCKS))  target channel index.
REQ-010 cfg_inc  input  ACC_W  new phase increment.
REQ-011 cfg_phase  input  ACC_W  accumulator load value (initial phase).
REQ-012 outclk  output  NUM_CLOCKS  per-channel generated clock (registered accumulator MSB).
REQ-013 outclk_en  output  NUM_CLOCKS  per-channel one-cycle strobe on accumulator wrap.
REQ-014 locked  output  1  all channels configured and settled.
REQ-015 cfg_err  output  1  one-cycle pulse on accepted request with invalid cfg_chan.

Function
REQ-016 Each cycle, every channel SHALL update acc <= (acc + inc) mod 2^ACC_W; outclk[i] SHALL be acc[ACC_W-1] registered; outclk_en[i] SHALL be the carry-out of that addition, registered.
REQ-017 Average outclk frequency SHALL equal f_refclk * inc / 2^ACC_W.
REQ-018 inc = 0 SHALL hold acc, outclk[i] = 0 and outclk_en[i] = 0.
REQ-019 inc > 2^(ACC_W-1) SHALL be saturated to 2^(ACC_W-1) at load (outclk = refclk/2).
REQ-020 Controller FSM states: HOLD, SETTLE, LOCKED.
REQ-021 HOLD: entered on reset; lasts 4 cycles after rst deasserts; accumulators frozen at 0; cfg_ready = 0; then -> SETTLE.
REQ-022 SETTLE: settle counter increments each cycle; after LOCK_CYCLES cycles in SETTLE -> LOCKED; locked = 1 from the first LOCKED cycle.
REQ-023 Transfer occurs on a cycle with cfg_valid & cfg_ready; cfg_ready SHALL be 1 in SETTLE and LOCKED.
REQ-024 Valid transfer: on the next edge the channel loads inc <= cfg_inc (after REQ-019), acc <= cfg_phase; FSM -> SETTLE with counter cleared; locked = 0 from that edge.
REQ-025 Transfer during SETTLE SHALL restart the settle count from zero.
REQ-026 Transfer with cfg_chan >= NUM_CLOCKS SHALL be accepted, change no channel or FSM state, and pulse cfg_err for one cycle.
REQ-027 Channels not targeted by a transfer SHALL continue accumulating without discontinuity.
REQ-028 Back-to-back transfers on consecutive cycles SHALL each be applied in order.

Reset
REQ-029 On rst assertion, immediately and asynchronously: acc = 0, inc = DEFAULT_INC (saturated per REQ-019), outclk = 0, outclk_en = 0, locked = 0, cfg_ready = 0, cfg_err = 0, FSM = HOLD, settle counter = 0.
REQ-030 rst asserted in any state, including mid-SETTLE or mid-transfer, SHALL discard pending configuration and restore DEFAULT_INC on all channels.

Structure
REQ-031 Package clkgen_pkg SHALL hold the FSM state enumeration, HOLD length constant (4), and the saturation helper function.
REQ-032 Sub-module clkgen_nco_chan (one accumulator, increment register, load/saturation, outclk/outclk_en registers) SHALL be instantiated NUM_CLOCKS times; FSM and handshake stay in clkgen_nco.

Verification
REQ-033 Defaults, ACC_W=32: release reset, count 3125 cycles after lock -> exactly 1000 outclk_en pulses per channel.
REQ-034 LOCK_CYCLES=1024: rst deasserted -> locked rises on edge 1028 after release; cfg_ready rises on edge 4.
REQ-035 Transfer chan 1, inc 32'h40000000, phase 0 while locked -> locked 0 next edge, outclk[1] period 4 cycles duty 50%, channel 0 undisturbed, locked back after 1024 cycles.
REQ-036 Transfer inc 32'hFFFFFFFF -> behaves as 32'h80000000, outclk toggles every cycle; inc 0 -> outclk and outclk_en held 0.
REQ-037 NUM_CLOCKS=2, transfer cfg_chan 3 while locked -> cfg_err single pulse, locked stays 1, both channels unchanged.
REQ-038 Transfer at SETTLE cycle 500, then rst pulse at SETTLE cycle 300 -> settle restarts each time; after reset all incs equal DEFAULT_INC, locked at edge 1028.
